// File: rtl/patdet_pkg.sv
// Shared definitions for the pattern_detector codebase slice.
// Contents:
//   PATDET_MAX_W       widest supported pattern; config fields are stored at this width
//   PATDET_RST_OVERLAP default overlap mode after reset
//   PATDET_MASK_ALL    all-ones compare mask (every bit compared)
//   patdet_cfg_t       runtime configuration {pattern, mask, overlap}
//   FILL_W()           width of the fill counter for a given pattern length
package patdet_pkg;

    localparam int PATDET_MAX_W = 32;

    localparam logic PATDET_RST_OVERLAP = 1'b1;

    localparam logic [PATDET_MAX_W-1:0] PATDET_MASK_ALL = {PATDET_MAX_W{1'b1}};

    // Pattern and mask are zero-extended to PATDET_MAX_W so one struct serves
    // every PAT_W; zero mask bits above PAT_W make the extra bits don't-care.
    typedef struct packed {
        logic [PATDET_MAX_W-1:0] pattern;
        logic [PATDET_MAX_W-1:0] mask;
        logic                    overlap;
    } patdet_cfg_t;

    function automatic int FILL_W(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/patdet_window.sv
// Sample window of the pattern detector: shift register, fill counter and
// masked compare against the active configuration.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   i_clr     cfg_load pulse: empties the window and suppresses the hit
//   i_en      sample qualifier
//   i_in      serial data bit
//   i_cfg     active pattern / mask / overlap configuration
//   o_hit     combinational hit for the current edge (already gated by i_en, i_clr)
//   o_fill    registered count of valid samples in the window (0..PAT_W)
module patdet_window
    import patdet_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic                      i_in,
    input  patdet_cfg_t               i_cfg,
    output logic                      o_hit,
    output logic [FILL_W(PAT_W)-1:0]  o_fill
);

    localparam int FW = FILL_W(PAT_W);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    // Only PAT_W-1 past samples are stored: the oldest bit of the window would
    // be shifted out by the very edge that next compares it, so the full
    // window is always {r_hist, i_in}.
    logic [PAT_W-2:0]        r_hist;
    logic [FW-1:0]           r_fill;
    logic [PAT_W-1:0]        w_hist_next;
    logic [FW-1:0]           w_fill_next;
    logic [PATDET_MAX_W-1:0] w_diff;
    logic                    w_hit;

    // Next window contents, saturating fill and masked compare
    always_comb begin
        w_hist_next = {r_hist, i_in};
        if (r_fill == FILL_FULL) begin
            w_fill_next = r_fill;
        end else begin
            w_fill_next = r_fill + FW'(1'b1);
        end
        w_diff = (PATDET_MAX_W'(w_hist_next) ^ i_cfg.pattern) & i_cfg.mask;
        if (i_en && !i_clr && (w_fill_next == FILL_FULL) &&
            (w_diff == {PATDET_MAX_W{1'b0}})) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
    end

    // Window state: cleared by config load or a non-overlapping hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= {(PAT_W-1){1'b0}};
            r_fill <= {FW{1'b0}};
        end else if (i_clr) begin
            r_hist <= {(PAT_W-1){1'b0}};
            r_fill <= {FW{1'b0}};
        end else if (i_en) begin
            if (w_hit && !i_cfg.overlap) begin
                r_hist <= {(PAT_W-1){1'b0}};
                r_fill <= {FW{1'b0}};
            end else begin
                r_hist <= w_hist_next[PAT_W-2:0];
                r_fill <= w_fill_next;
            end
        end else begin
            r_hist <= r_hist;
            r_fill <= r_fill;
        end
    end

    assign o_hit  = w_hit;
    assign o_fill = r_fill;

endmodule

// File: rtl/pattern_detector.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern,
// don't-care mask, overlap mode and saturating match counter.
// Optional build macro: PATDET_STICKY_EN adds the match_sticky output.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   en, in                         sample qualifier and serial data bit
//   cfg_load, cfg_pattern,
//   cfg_mask, cfg_overlap          configuration load (clears the window)
//   cnt_clr                        synchronous clear of match_count
//   match                          registered one-cycle pulse per hit
//   match_count                    saturating hit counter
//   fill                           valid samples in the window
//   match_sticky (optional)        set on hit, cleared by cnt_clr or cfg_load
module pattern_detector
    import patdet_pkg::*;
#(
    parameter int               PAT_W       = 5,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(5'b11101),
    parameter logic [PAT_W-1:0] RST_MASK    = PATDET_MASK_ALL[PAT_W-1:0],
    parameter logic             RST_OVERLAP = PATDET_RST_OVERLAP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in,
    input  logic                      cfg_load,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic [PAT_W-1:0]          cfg_mask,
    input  logic                      cfg_overlap,
    input  logic                      cnt_clr,
    output logic                      match,
    output logic [CNT_W-1:0]          match_count,
    output logic [FILL_W(PAT_W)-1:0]  fill
`ifdef PATDET_STICKY_EN
    ,
    output logic                      match_sticky
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam patdet_cfg_t RST_CFG = '{
        pattern: PATDET_MAX_W'(RST_PATTERN),
        mask:    PATDET_MAX_W'(RST_MASK),
        overlap: RST_OVERLAP
    };

    patdet_cfg_t      r_cfg;
    patdet_cfg_t      w_cfg_new;
    logic             w_hit;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    // Zero-extend the incoming configuration to the stored width
    always_comb begin
        w_cfg_new.pattern = PATDET_MAX_W'(cfg_pattern);
        w_cfg_new.mask    = PATDET_MAX_W'(cfg_mask);
        w_cfg_new.overlap = cfg_overlap;
    end

    patdet_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (cfg_load),
        .i_en   (en),
        .i_in   (in),
        .i_cfg  (r_cfg),
        .o_hit  (w_hit),
        .o_fill (fill)
    );

    // Active configuration register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg <= RST_CFG;
        end else if (cfg_load) begin
            r_cfg <= w_cfg_new;
        end else begin
            r_cfg <= r_cfg;
        end
    end

    // Match flag: follows this edge's hit; en=0 edges give no hit and load 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match <= 1'b0;
        end else if (cfg_load) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
        end
    end

    // Saturating match counter; a clear discards a coincident hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (cfg_load) begin
            r_count <= r_count;
        end else if (cnt_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_hit && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;

`ifdef PATDET_STICKY_EN
    logic r_sticky;

    // Sticky hit flag: a hit wins over a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_hit) begin
            r_sticky <= 1'b1;
        end else if (cnt_clr || cfg_load) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= r_sticky;
        end
    end

    assign match_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector (PAT_W=5, CNT_W=2).
// Stimulus is driven on the falling edge; a sample-list reference model
// predicts match / match_count / fill after the next rising edge and pushes
// the prediction into a queue, which a monitor pops and compares just after
// each rising edge.
module tb_pattern_detector;

    localparam int PAT_W = 5;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             in_b = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = 5'b00000;
    logic [PAT_W-1:0] cfg_mask = 5'b00000;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [2:0]       fill;
`ifdef PATDET_STICKY_EN
    logic             match_sticky;
`endif

    pattern_detector #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in          (in_b),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .fill        (fill)
`ifdef PATDET_STICKY_EN
        ,
        .match_sticky (match_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int c;
        int f;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: list of samples received since the window was last emptied
    int         m_samples[$];
    int         m_count;
    logic [4:0] m_pat;
    logic [4:0] m_mask;
    logic       m_ov;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_samples.delete();
        m_count = 0;
        m_pat   = 5'b11101;
        m_mask  = 5'b11111;
        m_ov    = 1'b1;
    endtask

    task automatic model_step(input logic e, input logic b, input logic ld, input logic clr,
                              input logic [4:0] pat, input logic [4:0] msk, input logic ov);
        int   hit;
        exp_t x;
        hit = 0;
        if (ld) begin
            m_pat  = pat;
            m_mask = msk;
            m_ov   = ov;
            m_samples.delete();
        end else begin
            if (e) begin
                m_samples.push_back(int'(b));
                if (m_samples.size() > PAT_W) void'(m_samples.pop_front());
                if (m_samples.size() == PAT_W) begin
                    hit = 1;
                    // m_samples[0] is the oldest sample = pattern bit PAT_W-1
                    for (int k = 0; k < PAT_W; k++) begin
                        if (m_mask[PAT_W-1-k] && (m_samples[k] != int'(m_pat[PAT_W-1-k])))
                            hit = 0;
                    end
                end
                if (hit == 1 && !m_ov) m_samples.delete();
            end
            if (clr) m_count = 0;
            else if (hit == 1 && m_count < CMAX) m_count = m_count + 1;
        end
        x.m = hit;
        x.c = m_count;
        x.f = m_samples.size();
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic e, input logic b, input logic ld, input logic clr,
                         input logic [4:0] pat, input logic [4:0] msk, input logic ov);
        @(negedge clk);
        rst = 1'b0; en = e; in_b = b; cfg_load = ld; cnt_clr = clr;
        cfg_pattern = pat; cfg_mask = msk; cfg_overlap = ov;
        model_step(e, b, ld, clr, pat, msk, ov);
    endtask

    task automatic sample(input logic b);
        drive(1'b1, b, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0);
    endtask

    task automatic clear_cnt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, 1'b0);
    endtask

    task automatic load(input logic [4:0] pat, input logic [4:0] msk, input logic ov);
        drive(1'b0, 1'b0, 1'b1, 1'b0, pat, msk, ov);
    endtask

    // Feed n bits, oldest (bits[n-1]) first
    task automatic feed(input logic [31:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample(bits[n-1-i]);
            for (int g = 0; g < gap; g++) idle();
        end
    endtask

    // Direct check of DUT outputs just after the next rising edge
    task automatic settle_check(input string name, input int m, input int c, input int f);
        @(posedge clk);
        #1;
        chk({name, "_match"}, int'(match), m);
        chk({name, "_count"}, int'(match_count), c);
        chk({name, "_fill"}, int'(fill), f);
    endtask

    task automatic do_rst();
        exp_t x;
        @(negedge clk);
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
        #1;
        chk("rst_async_match", int'(match), 0);
        chk("rst_async_count", int'(match_count), 0);
        chk("rst_async_fill", int'(fill), 0);
        model_reset();
        x.m = 0; x.c = 0; x.f = 0;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs settle after every rising edge; compare with the oldest prediction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_match", int'(match), e.m);
            chk("sb_count", int'(match_count), e.c);
            chk("sb_fill", int'(fill), e.f);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rp, rm;
        logic       re, rb, rl, rc, ro;
        model_reset();
        do_rst();

        // Defaults: 1,1,1,0,1 hits on the 5th sample
        feed(32'b11101, 5, 0);
        settle_check("dflt", 1, 1, 5);
        idle();

        // 10101 overlapping: hits on samples 5 and 7
        clear_cnt();
        load(5'b10101, 5'b11111, 1'b1);
        feed(32'b1010101, 7, 0);
        settle_check("ovl", 1, 2, 5);
        // Non-overlapping: one hit, fill=2 after sample 7
        clear_cnt();
        load(5'b10101, 5'b11111, 1'b0);
        feed(32'b1010101, 7, 0);
        settle_check("novl", 0, 1, 2);

        // Don't-care middle bits
        clear_cnt();
        load(5'b10001, 5'b10001, 1'b1);
        feed(32'b11101, 5, 0);
        settle_check("mask_dc", 1, 1, 5);
        load(5'b10001, 5'b11111, 1'b1);
        feed(32'b11101, 5, 0);
        settle_check("mask_full", 0, 1, 5);

        // en gating: two idle cycles between samples
        clear_cnt();
        load(5'b11101, 5'b11111, 1'b1);
        feed(32'b11101, 5, 2);
        chk("gap_count", int'(match_count), 1);

        // All-zero mask: saturation, then clear beats a coincident hit
        clear_cnt();
        load(5'b00000, 5'b00000, 1'b1);
        feed(32'b10110100, 8, 0);
        settle_check("sat", 1, CMAX, 5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 5'b00000, 1'b0);
        settle_check("clr_hit", 1, 0, 5);

        // cfg_load mid-sequence empties the window
        load(5'b11101, 5'b11111, 1'b1);
        feed(32'b1110, 4, 0);
        load(5'b11101, 5'b11111, 1'b1);
        sample(1'b1);
        settle_check("reload", 0, 0, 1);

        // Asynchronous reset mid-stream after a counted hit
        feed(32'b11101, 5, 0);
        feed(32'b11, 2, 0);
        do_rst();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            re = ($urandom_range(0, 9) < 7);
            rb = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 99) < 3);
            rc = !rl && ($urandom_range(0, 99) < 5);
            rp = 5'($urandom_range(0, 31));
            rm = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            ro = 1'($urandom_range(0, 1));
            drive(re, rb, rl, rc, rp, rm, ro);
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
Name: pattern_detector

Overview:
Parametrised serial bit-pattern detector. Samples one bit per qualified clock and compares the last PAT_W samples against a runtime-loadable pattern and don't-care mask. Supports overlapping and non-overlapping match modes, and keeps a saturating match counter. Sits on serial input streams as the general replacement for fixed-sequence Moore detectors.

Parameters:
PAT_W, 5, pattern length in bits (2..32)
CNT_W, 8, match counter width (1..32)
RST_PATTERN, 5'b11101, pattern loaded at reset; bit PAT_W-1 = oldest (first received) bit, bit 0 = newest
RST_MASK, all ones, compare mask at reset; 1 = bit compared, 0 = don't-care
RST_OVERLAP, 1, overlap mode at reset

Ports:
clk  in  1  clock
rst  in  1  reset
en  in  1  sample qualifier; in is consumed on a rising edge only when en=1
in  in  1  serial data bit
cfg_load  in  1  loads cfg_pattern, cfg_mask and cfg_overlap on the edge
cfg_pattern  in  PAT_W  new pattern, same bit order as RST_PATTERN
cfg_mask  in  PAT_W  new compare mask
cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count
match  out  1  registered match flag (Moore-style)
match_count  out  CNT_W  saturating number of matches
fill  out  $clog2(PAT_W+1)  valid samples currently in the window (0..PAT_W)

Behaviour:
- Reset: clk is the clock; rst is asynchronous, active-high. On reset: hist=0, fill=0, match=0, match_count=0, pattern=RST_PATTERN, mask=RST_MASK, overlap=RST_OVERLAP.
- Window: on an edge with en=1, hist_next = {hist[PAT_W-2:0], in} and fill saturates at PAT_W.
- Hit condition, evaluated on the sampling edge: fill_next==PAT_W and ((hist_next ^ pattern) & mask)==0.
- match latency: match is 1 in the cycle following the sampling edge that produces a hit. The next edge loads match with that edge's hit result; an edge with en=0 loads 0. match is therefore a one-cycle pulse per hit, and back-to-back hits in overlap mode keep it high.
- Overlap=1: fill stays at PAT_W after a hit.
- Overlap=0: a hit sets fill_next to 0 and hist_next to 0. The next match needs PAT_W fresh samples.
- match_count: increments by 1 on each hit and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr: sets match_count to 0 and takes priority over a simultaneous hit, which is not counted. match is still asserted for that hit.
- cfg_load has the highest priority after rst. It latches the new config and sets hist=0, fill=0, match=0. en/in on that edge are ignored. match_count is preserved.
- Mask all zeros: every sample after the window has filled is a hit.
- en=0 cycles: hist, fill and match_count hold. Gaps between samples do not break a sequence.
- rst mid-sequence: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
PATDET_STICKY_EN
- Defined: adds output match_sticky (1 bit, reset 0). It is set on any hit and held until cnt_clr or cfg_load. When a hit coincides with a clear, the set wins.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package patdet_pkg holds:
  - fill width function FILL_W(PAT_W) = $clog2(PAT_W+1)
  - default constants for RST_OVERLAP and the mask
  - a config struct typedef {pattern, mask, overlap}
- One natural sub-module, patdet_window, contains the shift register, fill counter and masked compare, and outputs hit. The top level holds the config registers, the match register, the counter and the sticky flag.

Test Plan:
- Defaults, en=1, in stream 1,1,1,0,1: match=1 only in the cycle after the 5th edge; match_count=1; fill=5.
- Pattern 10101, mask 11111, stream 1,0,1,0,1,0,1: overlap=1 gives hits on samples 5 and 7 (count=2). overlap=0 gives one hit on sample 5 (count=1), and fill=2 after sample 7.
- Pattern 10001, mask 10001, stream 1,1,1,0,1: hit on the 5th sample (middle bits are don't-care). The same stream with mask 11111 gives no hit.
- en gating: the defaults stream 1,1,1,0,1 with two en=0 cycles between each sample gives exactly one hit and count=1.
- CNT_W=2, pattern 00000, mask 00000, overlap=1, 8 samples: hits on samples 5..8, count saturates at 3. Then cnt_clr on the same edge as a hit gives count=0 and match=1.
- After 4 samples of 1,1,1,0, cfg_load with the same config and then sample 1: no hit, fill=1. Separately, rst asserted mid-stream gives fill=0, match=0 and count=0 before the next edge.
